instr_encoder: RTL and testbench

- Encoder end of the instruction/control interface: accepts symbolic instruction requests (mnemonic code plus fields) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS32 instruction word using the same opcode/funct map the control decoder consumes.
- Writes words sequentially into instruction memory.
- Sits between the bench/boot loader and instruction memory; used to build test programs in simulation and on-chip.

---
 rtl/enc_pkg.sv | 84 ++++++++
 rtl/instr_field_pack.sv | 89 ++++++++
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared mnemonic, opcode and funct map for the instruction encoder.
// Same map the control decoder consumes; keep the two in sync.
package enc_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned TGT_W  = 26;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned WORD_W = 32;

    // Mnemonic codes presented on the request port
    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W-1:0] OP_AND   = 5'd2;
    localparam logic [OP_W-1:0] OP_OR    = 5'd3;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
    localparam logic [OP_W-1:0] OP_NOR   = 5'd6;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd7;
    localparam logic [OP_W-1:0] OP_SRL   = 5'd8;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd9;
    localparam logic [OP_W-1:0] OP_ROR   = 5'd10;
    localparam logic [OP_W-1:0] OP_ROL   = 5'd11;
    localparam logic [OP_W-1:0] OP_LW    = 5'd12;
    localparam logic [OP_W-1:0] OP_SW    = 5'd13;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'd14;
    localparam logic [OP_W-1:0] OP_BNE   = 5'd15;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'd16;
    localparam logic [OP_W-1:0] OP_SLTI  = 5'd17;
    localparam logic [OP_W-1:0] OP_SLTIU = 5'd18;
    localparam logic [OP_W-1:0] OP_ANDI  = 5'd19;
    localparam logic [OP_W-1:0] OP_ORI   = 5'd20;
    localparam logic [OP_W-1:0] OP_XORI  = 5'd21;
    localparam logic [OP_W-1:0] OP_LUI   = 5'd22;
    localparam logic [OP_W-1:0] OP_J     = 5'd23;
    localparam logic [OP_W-1:0] OP_JAL   = 5'd24;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 5'd25;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OPC_SLTIU = 6'b001011;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_XORI  = 6'b001110;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'b001111;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'b000011;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FN_W-1:0] FN_XOR = 6'b100110;
    localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FN_W-1:0] FN_SRL = 6'b000010;
    localparam logic [FN_W-1:0] FN_SRA = 6'b000011;
    localparam logic [FN_W-1:0] FN_ROR = 6'b111000;
    localparam logic [FN_W-1:0] FN_ROL = 6'b111001;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FULL} state_t;

    // Symbolic request payload
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] shamt;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } enc_req_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic request -> {legal, 32-bit MIPS32 word}.
// ENC_FIELD_CHECK_EN additionally rejects requests whose destination is $0 (JAL exempt).
module instr_field_pack
    import enc_pkg::*;
(
    input  enc_req_t          req,
    output logic              legal_c,
    output logic [WORD_W-1:0] word_c
);

    logic              op_legal;
    fmt_t              fmt;
    logic [OPC_W-1:0]  opc;
    logic [FN_W-1:0]   fn;
    logic [REG_W-1:0]  rs_f;
    logic [REG_W-1:0]  shamt_f;

    // Decode mnemonic into format, opcode/funct and forced-zero fields
    always_comb begin
        op_legal = 1'b1;
        fmt      = FMT_R;
        opc      = OPC_RTYPE;
        fn       = FN_ADD;
        rs_f     = req.rs;
        shamt_f  = '0;
        case (req.op)
            OP_ADD:   fn = FN_ADD;
            OP_SUB:   fn = FN_SUB;
            OP_AND:   fn = FN_AND;
            OP_OR:    fn = FN_OR;
            OP_SLT:   fn = FN_SLT;
            OP_XOR:   fn = FN_XOR;
            OP_NOR:   fn = FN_NOR;
            OP_SLL:   begin fn = FN_SLL; rs_f = '0; shamt_f = req.shamt; end
            OP_SRL:   begin fn = FN_SRL; rs_f = '0; shamt_f = req.shamt; end
            OP_SRA:   begin fn = FN_SRA; rs_f = '0; shamt_f = req.shamt; end
            OP_ROR:   begin fn = FN_ROR; rs_f = '0; shamt_f = req.shamt; end
            OP_ROL:   begin fn = FN_ROL; rs_f = '0; shamt_f = req.shamt; end
            OP_LW:    begin fmt = FMT_I; opc = OPC_LW;    end
            OP_SW:    begin fmt = FMT_I; opc = OPC_SW;    end
            OP_BEQ:   begin fmt = FMT_I; opc = OPC_BEQ;   end
            OP_BNE:   begin fmt = FMT_I; opc = OPC_BNE;   end
            OP_ADDI:  begin fmt = FMT_I; opc = OPC_ADDI;  end
            OP_SLTI:  begin fmt = FMT_I; opc = OPC_SLTI;  end
            OP_SLTIU: begin fmt = FMT_I; opc = OPC_SLTIU; end
            OP_ANDI:  begin fmt = FMT_I; opc = OPC_ANDI;  end
            OP_ORI:   begin fmt = FMT_I; opc = OPC_ORI;   end
            OP_XORI:  begin fmt = FMT_I; opc = OPC_XORI;  end
            OP_LUI:   begin fmt = FMT_I; opc = OPC_LUI; rs_f = '0; end
            OP_J:     begin fmt = FMT_J; opc = OPC_J;     end
            OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL;   end
            default:  op_legal = 1'b0;
        endcase
    end

    // Assemble the instruction word
    always_comb begin
        word_c = '0;
        case (fmt)
            FMT_R:   word_c = {OPC_RTYPE, rs_f, req.rt, req.rd, shamt_f, fn};
            FMT_I:   word_c = {opc, rs_f, req.rt, req.imm};
            FMT_J:   word_c = {opc, req.target};
            default: word_c = '0;
        endcase
        if (!op_legal) begin
            word_c = '0;
        end
    end

`ifdef ENC_FIELD_CHECK_EN
    logic dst_zero;

    // Destination register is rd for R-type, rt for writing I-types
    always_comb begin
        dst_zero = 1'b0;
        if (fmt == FMT_R) begin
            dst_zero = (req.rd == '0);
        end else if (fmt == FMT_I && req.op != OP_SW && req.op != OP_BEQ
                     && req.op != OP_BNE) begin
            dst_zero = (req.rt == '0);
        end
    end

    assign legal_c = op_legal && !dst_zero;
`else
    assign legal_c = op_legal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: valid/ready requests packed to MIPS32 words and written sequentially to imem.
// Optional ENC_FIELD_CHECK_EN rejects writes to $0 (handled in instr_field_pack).
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OP_W-1:0]   i_op,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [REG_W-1:0]  i_shamt,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [TGT_W-1:0]  i_target,
    input  logic              i_flush,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err_illegal
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    enc_req_t          req;
    logic              legal_c;
    logic [WORD_W-1:0] word_c;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    assign req = '{op: i_op, rs: i_rs, rt: i_rt, rd: i_rd, shamt: i_shamt,
                   imm: i_imm, target: i_target};

    instr_field_pack u_pack (
        .req     (req),
        .legal_c (legal_c),
        .word_c  (word_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next state and next registered outputs; the write pointer is the low bits of count
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        err_d   = err_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    if (legal_c) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = word_c;
                        ready_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + CNT_W'(1);
                if (count_d == CAPACITY) begin
                    state_d = ST_FULL;
                    full_d  = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_FULL: begin
                full_d  = 1'b1;
                ready_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
        // Flush wins over accept and over the pointer increment of a running write
        if (i_flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            we_d    = 1'b0;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            full_d  = 1'b0;
            err_d   = 1'b0;
            ready_d = 1'b1;
        end
    end

    assign o_ready       = ready_q;
    assign o_imem_we     = we_q;
    assign o_imem_addr   = addr_q;
    assign o_imem_wdata  = wdata_q;
    assign o_count       = count_q;
    assign o_full        = full_q;
    assign o_err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of encodings checked through a write scoreboard,
// plus hand sequences for flush, full (ADDR_W=2 instance) and async reset.
module tb_instr_encoder;

`ifdef ENC_FIELD_CHECK_EN
    localparam bit FIELD_CHK = 1'b1;
`else
    localparam bit FIELD_CHK = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] word;
    } sb_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic [4:0]  i_op = '0, i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
    logic [15:0] i_imm = '0;
    logic [25:0] i_target = '0;

    logic        o_ready, o_imem_we, o_full, o_err_illegal;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic [8:0]  o_count;

    logic        s_ready, s_we, s_full, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_count = 0;
    int   s_writes = 0;
    logic [1:0]  s_last_addr = '0;
    logic [31:0] s_last_word = '0;
    sb_t  sb[$];
    vec_t tbl[$];

    always #5 i_clk = ~i_clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
        .i_imm(i_imm), .i_target(i_target), .i_flush(i_flush),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_count(o_count), .o_full(o_full), .o_err_illegal(o_err_illegal)
    );

    instr_encoder #(.ADDR_W(2)) dut_s (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(s_ready),
        .i_op(i_op), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
        .i_imm(i_imm), .i_target(i_target), .i_flush(i_flush),
        .o_imem_we(s_we), .o_imem_addr(s_addr), .o_imem_wdata(s_wdata),
        .o_count(s_count), .o_full(s_full), .o_err_illegal(s_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                                input logic [25:0] tgt, input bit legal, input logic [31:0] word);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = sh;
        v.imm = imm; v.target = tgt; v.legal = legal; v.word = word;
        return v;
    endfunction

    // Scoreboard for the main instance: every write strobe must match the oldest expectation
    always @(negedge i_clk) begin
        if (i_rst_n && o_imem_we) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_we: got addr 0x%02h data 0x%08h want no write",
                         o_imem_addr, o_imem_wdata);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_addr", 32'(o_imem_addr), 32'(e.addr));
                check("sb_wdata", o_imem_wdata, e.word);
            end
        end
        if (i_rst_n && s_we) begin
            s_writes++;
            s_last_addr = s_addr;
            s_last_word = s_wdata;
        end
    end

    task automatic drive(input vec_t v);
        i_op = v.op; i_rs = v.rs; i_rt = v.rt; i_rd = v.rd;
        i_shamt = v.shamt; i_imm = v.imm; i_target = v.target;
        i_valid = 1'b1;
    endtask

    // One handshake on the main instance; returns #1 after the write cycle (or accept edge if rejected)
    task automatic apply(input vec_t v);
        int n;
        drive(v);
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready 0 want 1 within 50 cycles");
            i_valid = 1'b0;
            return;
        end
        if (v.legal) sb.push_back('{addr: 8'(exp_count), word: v.word});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (v.legal) begin
            check("we_latency", 32'(o_imem_we), 32'd1);
            check("ready_busy", 32'(o_ready), 32'd0);
            @(posedge i_clk); #1;
            exp_count++;
            check("count", 32'(o_count), 32'(exp_count));
        end else begin
            check("illegal_no_we", 32'(o_imem_we), 32'd0);
            check("illegal_err", 32'(o_err_illegal), 32'd1);
            check("illegal_count", 32'(o_count), 32'(exp_count));
        end
    endtask

    task automatic flush_cycle();
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        exp_count = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Encodings worked out by hand from the opcode/funct map
        tbl.push_back(mk(5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       1, 32'h00221820)); // ADD
        tbl.push_back(mk(5'd7,  5'd7,  5'd5,  5'd4,  5'd2,  16'h0,    26'h0,       1, 32'h00052080)); // SLL rs forced 0
        tbl.push_back(mk(5'd12, 5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,       1, 32'h8FA80004)); // LW
        tbl.push_back(mk(5'd23, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h10,      1, 32'h08000010)); // J
        tbl.push_back(mk(5'd24, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h10,      1, 32'h0C000010)); // JAL
        tbl.push_back(mk(5'd1,  5'd4,  5'd5,  5'd6,  5'd3,  16'h0,    26'h0,       1, 32'h00853022)); // SUB shamt forced 0
        tbl.push_back(mk(5'd9,  5'd12, 5'd31, 5'd31, 5'd31, 16'h0,    26'h0,       1, 32'h001FFFC3)); // SRA
        tbl.push_back(mk(5'd11, 5'd0,  5'd1,  5'd2,  5'd4,  16'h0,    26'h0,       1, 32'h00011139)); // ROL
        tbl.push_back(mk(5'd10, 5'd0,  5'd3,  5'd4,  5'd8,  16'h0,    26'h0,       1, 32'h00032238)); // ROR
        tbl.push_back(mk(5'd6,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       1, 32'h00221827)); // NOR
        tbl.push_back(mk(5'd31, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       0, 32'h0));        // illegal
        tbl.push_back(mk(5'd20, 5'd0,  5'd4,  5'd0,  5'd0,  16'h1234, 26'h0,       1, 32'h34041234)); // ORI
        tbl.push_back(mk(5'd22, 5'd9,  5'd1,  5'd0,  5'd0,  16'hABCD, 26'h0,       1, 32'h3C01ABCD)); // LUI rs forced 0
        tbl.push_back(mk(5'd13, 5'd2,  5'd3,  5'd0,  5'd0,  16'hFFFC, 26'h0,       1, 32'hAC43FFFC)); // SW
        tbl.push_back(mk(5'd15, 5'd1,  5'd0,  5'd0,  5'd0,  16'h8000, 26'h0,       1, 32'h14208000)); // BNE rt=0
        tbl.push_back(mk(5'd18, 5'd31, 5'd31, 5'd0,  5'd0,  16'hFFFF, 26'h0,       1, 32'h2FFFFFFF)); // SLTIU
        tbl.push_back(mk(5'd25, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       0, 32'h0));        // illegal min
        tbl.push_back(mk(5'd24, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1, 32'h0FFFFFFF)); // JAL max
        tbl.push_back(mk(5'd21, 5'd1,  5'd2,  5'd0,  5'd0,  16'h00FF, 26'h0,       1, 32'h382200FF)); // XORI
        tbl.push_back(mk(5'd16, 5'd1,  5'd0,  5'd0,  5'd0,  16'h0005, 26'h0, !FIELD_CHK, 32'h20200005)); // ADDI rt=0

        #12;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_we", 32'(o_imem_we), 32'd0);
        check("rst_addr", 32'(o_imem_addr), 32'd0);
        check("rst_wdata", o_imem_wdata, 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_err", 32'(o_err_illegal), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        foreach (tbl[i]) apply(tbl[i]);
        check("err_sticky", 32'(o_err_illegal), 32'd1);

        flush_cycle();
        check("flush_err", 32'(o_err_illegal), 32'd0);
        check("flush_count", 32'(o_count), 32'd0);
        apply(tbl[11]);

        // Flush and valid together in IDLE: not accepted
        drive(tbl[0]);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        exp_count = 0;
        check("flushvalid_we", 32'(o_imem_we), 32'd0);
        check("flushvalid_ready", 32'(o_ready), 32'd1);
        check("flushvalid_count", 32'(o_count), 32'd0);
        @(posedge i_clk); #1;
        check("flushvalid_we2", 32'(o_imem_we), 32'd0);

        // Flush during WRITE: strobe completes, pointer not advanced
        apply(tbl[2]);
        drive(tbl[3]);
        sb.push_back('{addr: 8'(exp_count), word: tbl[3].word});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_flush = 1'b1;
        check("wrflush_we", 32'(o_imem_we), 32'd1);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        exp_count = 0;
        check("wrflush_count", 32'(o_count), 32'd0);
        check("wrflush_ready", 32'(o_ready), 32'd1);
        apply(tbl[4]);

        // Small instance: fill four words, then full
        flush_cycle();
        s_writes = 0;
        for (int k = 0; k < 4; k++) begin
            v = mk(5'd0, 5'd1, 5'd2, 5'(k + 1), 5'd0, 16'h0, 26'h0, 1, 32'h00220020 | (32'(k + 1) << 11));
            apply(v);
            check("small_addr", 32'(s_last_addr), 32'(k));
            check("small_wdata", s_last_word, v.word);
        end
        check("small_full", 32'(s_full), 32'd1);
        check("small_ready", 32'(s_ready), 32'd0);
        check("small_count", 32'(s_count), 32'd4);
        apply(tbl[7]);
        check("small_ignored_writes", 32'(s_writes), 32'd4);
        check("small_ignored_count", 32'(s_count), 32'd4);
        flush_cycle();
        check("small_flush_count", 32'(s_count), 32'd0);
        check("small_flush_ready", 32'(s_ready), 32'd1);
        check("small_flush_full", 32'(s_full), 32'd0);
        apply(tbl[8]);
        check("small_wrap_writes", 32'(s_writes), 32'd5);
        check("small_wrap_addr", 32'(s_last_addr), 32'd0);

        // Async reset in the middle of WRITE
        drive(tbl[9]);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("rstw_we_before", 32'(o_imem_we), 32'd1);
        #1 i_rst_n = 1'b0;
        #1;
        check("rstw_we", 32'(o_imem_we), 32'd0);
        check("rstw_addr", 32'(o_imem_addr), 32'd0);
        check("rstw_wdata", o_imem_wdata, 32'd0);
        check("rstw_count", 32'(o_count), 32'd0);
        check("rstw_ready", 32'(o_ready), 32'd1);
        check("rstw_small_we", 32'(s_we), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_count = 0;
        @(posedge i_clk); #1;
        apply(tbl[0]);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
